mc_sequencer: RTL and testbench

- Multi-cycle control FSM for the 8-bit CPU datapath: PC, reg16x8, RAM256x8, ALU and the mem_to_reg mux.
- Captures the two-byte instruction (opcode1/opcode2) into an internal IR and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives RAM strobes, register-write pulse, ALU enable and PC advance with defined cycle timing.
- Holds registered Carry/Zero flags for conditional jumps. Replaces the single-cycle combinational Controller.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/mc_branch_eval.sv | 17 +
 rtl/mc_sequencer.sv | 124 ++++++++++++
 tb/tb_mc_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, opcode-class, jump-condition and writeback-select constants
package cpu_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JMP  = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b0101;
  localparam logic [2:0] JC_ALW = 3'b000;
  localparam logic [2:0] JC_C   = 3'b001;
  localparam logic [2:0] JC_NC  = 3'b101;
  localparam logic [2:0] JC_Z   = 3'b010;
  localparam logic [2:0] JC_NZ  = 3'b110;
  localparam logic [1:0] MTR_IMM  = 2'b00;
  localparam logic [1:0] MTR_RAM  = 2'b01;
  localparam logic [1:0] MTR_ALU  = 2'b10;
  localparam logic [1:0] MTR_IDLE = 2'b11;
endpackage

// File: rtl/mc_branch_eval.sv
// mc_branch_eval: resolves a jump condition code against the registered flags
module mc_branch_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       carry_q,
  input  logic       zero_q,
  output logic       taken
);
  // unlisted condition codes fall through to not-taken
  always_comb
    taken = (cond == JC_ALW) ? 1'b1 :
            (cond == JC_C)   ? carry_q :
            (cond == JC_NC)  ? !carry_q :
            (cond == JC_Z)   ? zero_q :
            (cond == JC_NZ)  ? !zero_q : 1'b0;
endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 8-bit CPU
module mc_sequencer
  import cpu_pkg::*;
#(
  parameter int         DATA_W      = 8,
  parameter logic [3:0] HALT_NIBBLE = OP_HALT
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] opcode1,
  input  logic [DATA_W-1:0] opcode2,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] ir_op1,
  output logic [DATA_W-1:0] ir_op2,
  output logic              ir_load,
  output logic              n_cs,
  output logic              n_oe,
  output logic              n_we,
  output logic              alu_op,
  output logic [2:0]        alu_func,
  output logic [1:0]        mem_to_reg,
  output logic              regdest,
  output logic              regWrite,
  output logic              jumpCond,
  output logic              pc_en,
  output logic              halted,
  output logic [2:0]        state
);
  state_t     st, st_nx;
  logic       carry_q, zero_q, taken;
  logic [3:0] nib;
  logic       is_ldi, is_ld, is_st, is_jmp, is_alu, is_halt, is_nop;
  assign nib      = ir_op1[7:4];
  assign is_alu   = nib[3];
  assign is_ldi   = !is_alu && nib == OP_LDI;
  assign is_ld    = !is_alu && nib == OP_LD;
  assign is_st    = !is_alu && nib == OP_ST;
  assign is_jmp   = !is_alu && nib == OP_JMP;
  assign is_halt  = !is_alu && nib == HALT_NIBBLE;
  assign is_nop   = !(is_alu || is_ldi || is_ld || is_st || is_jmp || is_halt);
  assign alu_func = ir_op1[6:4];
  assign state    = st;
  mc_branch_eval u_branch (
    .cond    (ir_op1[2:0]),
    .carry_q (carry_q),
    .zero_q  (zero_q),
    .taken   (taken)
  );
  // state, instruction register and flags; IR loads only in FETCH, flags only in ALU EXEC
  always_ff @(posedge clk)
    if (!n_reset) begin
      st      <= FETCH;
      ir_op1  <= '0;
      ir_op2  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      st <= st_nx;
      if (st == FETCH) begin
        ir_op1 <= opcode1;
        ir_op2 <= opcode2;
      end
      if (st == EXEC && is_alu) begin
        carry_q <= alu_carry;
        zero_q  <= alu_zero;
      end
    end
  // next state and Moore strobes; everything is held idle while reset is asserted
  always_comb begin
    st_nx      = st;
    ir_load    = 1'b0;
    n_cs       = 1'b1;
    n_oe       = 1'b1;
    n_we       = 1'b1;
    alu_op     = 1'b0;
    mem_to_reg = MTR_IDLE;
    regdest    = 1'b1;
    regWrite   = 1'b0;
    jumpCond   = 1'b0;
    pc_en      = 1'b0;
    halted     = 1'b0;
    if (n_reset)
      case (st)
        FETCH: begin
          ir_load = 1'b1;
          st_nx   = DECODE;
        end
        DECODE: begin
          pc_en = is_nop;
          st_nx = is_ldi ? WB : (is_ld || is_st) ? MEM :
                  (is_alu || is_jmp) ? EXEC : is_halt ? HALT : FETCH;
        end
        EXEC: begin
          alu_op     = is_alu;
          mem_to_reg = is_alu ? MTR_ALU : MTR_IDLE;
          pc_en      = !is_alu;
          jumpCond   = !is_alu && taken;
          st_nx      = is_alu ? WB : FETCH;
        end
        MEM: begin
          n_cs       = 1'b0;
          n_oe       = !is_ld;
          n_we       = is_ld;
          mem_to_reg = is_ld ? MTR_RAM : MTR_IDLE;
          pc_en      = !is_ld;
          st_nx      = is_ld ? WB : FETCH;
        end
        WB: begin
          regWrite   = 1'b1;
          pc_en      = 1'b1;
          n_cs       = !is_ld;
          n_oe       = !is_ld;
          mem_to_reg = is_ld ? MTR_RAM : is_alu ? MTR_ALU : MTR_IMM;
          st_nx      = FETCH;
        end
        HALT: begin
          halted = 1'b1;
          st_nx  = HALT;
        end
        default: st_nx = FETCH;
      endcase
  end
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: random and directed instruction streams checked against a per-instruction timing model
module tb_mc_sequencer;
  import cpu_pkg::*;
  localparam int C_NOP = 0, C_LDI = 1, C_LD = 2, C_ST = 3, C_JMP = 4, C_ALU = 5, C_HALT = 6;
  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] opcode1, opcode2;
  logic       alu_carry, alu_zero;
  logic [7:0] ir_op1, ir_op2;
  logic       ir_load, n_cs, n_oe, n_we, alu_op, regdest, regWrite, jumpCond, pc_en, halted;
  logic [2:0] alu_func, state;
  logic [1:0] mem_to_reg;
  int         checks = 0, errors = 0;
  logic       cq, zq;
  logic [7:0] prev1, prev2;
  int         lat_tab [7] = '{2, 3, 4, 3, 3, 4, 0};
  localparam logic [11:0] IDLE_V = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  mc_sequencer dut (
    .clk(clk), .n_reset(n_reset), .opcode1(opcode1), .opcode2(opcode2),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .ir_op1(ir_op1), .ir_op2(ir_op2),
    .ir_load(ir_load), .n_cs(n_cs), .n_oe(n_oe), .n_we(n_we), .alu_op(alu_op),
    .alu_func(alu_func), .mem_to_reg(mem_to_reg), .regdest(regdest), .regWrite(regWrite),
    .jumpCond(jumpCond), .pc_en(pc_en), .halted(halted), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [11:0] obs_vec();
    return {ir_load, n_cs, n_oe, n_we, alu_op, mem_to_reg, regdest, regWrite, jumpCond, pc_en, halted};
  endfunction
  function automatic int cls_of(input logic [7:0] o1);
    if (o1[7]) return C_ALU;
    case (o1[7:4])
      4'h1: return C_LDI;
      4'h2: return C_LD;
      4'h3: return C_ST;
      4'h4: return C_JMP;
      4'h5: return C_HALT;
      default: return C_NOP;
    endcase
  endfunction
  function automatic logic taken_m(input logic [2:0] cc);
    case (cc)
      3'b000: return 1'b1;
      3'b001: return cq;
      3'b101: return !cq;
      3'b010: return zq;
      3'b110: return !zq;
      default: return 1'b0;
    endcase
  endfunction
  // expected strobes for cycle k of an instruction of class cl lasting lat cycles
  function automatic logic [11:0] exp_vec(input int cl, input int k, input int lat, input logic tk);
    logic last, ldm, stm;
    logic [1:0] mtr;
    last = (k == lat - 1);
    ldm  = (cl == C_LD) && k >= 2;
    stm  = (cl == C_ST) && k == 2;
    mtr  = ((cl == C_LDI) && k == 2) ? 2'b00 : ldm ? 2'b01 : ((cl == C_ALU) && k >= 2) ? 2'b10 : 2'b11;
    return {k == 0, !(ldm || stm), !ldm, !stm, (cl == C_ALU) && k == 2, mtr, 1'b1,
            last && (cl == C_LDI || cl == C_LD || cl == C_ALU),
            (cl == C_JMP) && k == 2 && tk, last, (cl == C_HALT) && k >= 2};
  endfunction
  task automatic do_reset_cycle(input string tag);
    n_reset = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(obs_vec()), 32'(IDLE_V));
    @(posedge clk); #1;
    cq = 1'b0; zq = 1'b0; prev1 = 8'h00; prev2 = 8'h00;
  endtask
  // runs one instruction; abort_at >= 0 asserts reset during that cycle and the next
  task automatic run(input logic [7:0] o1, input logic [7:0] o2, input logic c, input logic z, input int abort_at);
    int cl, n;
    logic tk;
    cl = cls_of(o1);
    n  = (cl == C_HALT) ? 12 : lat_tab[cl];
    tk = taken_m(o1[2:0]);
    for (int k = 0; k < n; k++) begin
      opcode1   = (k == 0) ? o1 : 8'($urandom);
      opcode2   = (k == 0) ? o2 : 8'($urandom);
      alu_carry = c;
      alu_zero  = z;
      if (k == abort_at) begin
        do_reset_cycle("abort");
        do_reset_cycle("abort2");
        chk("abort_ir", {ir_op1, ir_op2}, 16'h0000);
        n_reset = 1'b1;
        return;
      end
      @(negedge clk);
      chk($sformatf("strobes_%02h_k%0d", o1, k), 32'(obs_vec()), 32'(exp_vec(cl, k, lat_tab[cl], tk)));
      if (k == 0) begin
        chk("fetch_state", 32'(state), 32'(FETCH));
        chk("ir_hold", {ir_op1, ir_op2}, {prev1, prev2});
      end else begin
        chk("ir", {ir_op1, ir_op2}, {o1, o2});
        chk("alu_func", 32'(alu_func), 32'(o1[6:4]));
      end
      @(posedge clk); #1;
    end
    if (cl == C_ALU) begin
      cq = c;
      zq = z;
    end
    prev1 = o1;
    prev2 = o2;
  endtask
  initial begin
    logic [3:0] nib;
    n_reset = 1'b0; opcode1 = 8'h00; opcode2 = 8'h00; alu_carry = 1'b0; alu_zero = 1'b0;
    cq = 1'b0; zq = 1'b0; prev1 = 8'h00; prev2 = 8'h00;
    @(posedge clk); #1;
    do_reset_cycle("reset");
    chk("reset_ir", {ir_op1, ir_op2}, 16'h0000);
    n_reset = 1'b1;
    run(8'h13, 8'h2A, 1'b0, 1'b0, -1);
    run(8'h25, 8'h40, 1'b1, 1'b1, -1);
    run(8'h37, 8'h40, 1'b1, 1'b1, -1);
    run(8'h80, 8'h01, 1'b1, 1'b0, -1);
    run(8'h41, 8'h80, 1'b0, 1'b0, -1);
    run(8'h80, 8'h01, 1'b0, 1'b0, -1);
    run(8'h41, 8'h80, 1'b1, 1'b1, -1);
    run(8'h90, 8'h02, 1'b0, 1'b1, -1);
    run(8'h13, 8'h05, 1'b0, 1'b0, -1);
    run(8'h46, 8'h10, 1'b1, 1'b0, -1);
    run(8'h40, 8'h20, 1'b0, 1'b0, -1);
    run(8'h07, 8'h00, 1'b1, 1'b1, -1);
    for (int i = 0; i < 150; i++) begin
      nib = 4'($urandom_range(0, 15));
      if (nib == 4'h5) nib = 4'h4;
      run({nib, 4'($urandom)}, 8'($urandom), 1'($urandom), 1'($urandom), -1);
    end
    run(8'hA3, 8'h04, 1'b1, 1'b0, -1);
    run(8'h3C, 8'h40, 1'b0, 1'b0, 2);
    run(8'h41, 8'h80, 1'b1, 1'b1, -1);
    run(8'h50, 8'h00, 1'b0, 1'b0, -1);
    do_reset_cycle("halt_reset");
    n_reset = 1'b1;
    run(8'h13, 8'h2A, 1'b0, 1'b0, -1);
    run(8'h42, 8'h11, 1'b0, 1'b0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
